// File: rtl/pwm_mc_v2_pkg.sv
// pkg_sfrs_definition: shared PWM mode and configuration types
package pkg_sfrs_definition;
    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
    localparam int PWM_N = 16;
    typedef struct packed {
        logic [PWM_N-1:0] dc;
        logic [PWM_N-1:0] ph;
    } pwm_mc_cfg_t;
endpackage

// File: rtl/pwm_mc_v2_ch.sv
// pwm_mc_ch: one PWM channel with shadowed duty/phase compare and output stage
module pwm_mc_ch
    import pkg_sfrs_definition::*;
#(
    parameter int N = 16
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    input  logic      en,
    input  logic      tick,
    input  logic      ld,
    input  pwm_mode_e sh_mode,
    input  logic [N-1:0] tmr,
    input  logic [N-1:0] dc_cfg,
    input  logic [N-1:0] ph_cfg,
    input  logic      pol,
    input  logic      oen,
    output logic      dc_event,
    output logic      pwm_out
);
    logic [N-1:0] sh_dc, sh_ph;
    logic out_ff, raw;
    // center mode is symmetric about zero, so the phase compare drops out
    always_comb raw = (tmr < sh_dc) & ((sh_mode == PWM_CENTER) | (tmr >= sh_ph));
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sh_dc    <= '0;
            sh_ph    <= '0;
            out_ff   <= 1'b0;
            dc_event <= 1'b0;
        end else begin
            if (ld) begin
                sh_dc <= dc_cfg;
                sh_ph <= ph_cfg;
            end
            out_ff   <= en & raw;
            dc_event <= tick & (tmr == sh_dc);
        end
    end
    assign pwm_out = (out_ff ^ pol) & oen;
endmodule

// File: rtl/pwm_mc_v2.sv
// pwm_mc_v2: multi-channel PWM with shared prescaled edge/center timebase
// and boundary-synchronised shadow registers
module pwm_mc_v2
    import pkg_sfrs_definition::*;
#(
    parameter int N    = 16,
    parameter int CH   = 4,
    parameter int PS_W = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            sys_clk_en,
    input  logic            en,
    input  logic            mode_cfg,
    input  logic [PS_W-1:0] prescale,
    input  logic [N-1:0]    pr_cfg,
    input  logic [CH*N-1:0] dc_cfg,
    input  logic [CH*N-1:0] ph_cfg,
    input  logic [CH-1:0]   pol,
    input  logic [CH-1:0]   oen,
    input  logic            ld_trg,
    input  logic            tmr_rst,
    output logic            ld_pend,
    output logic [N-1:0]    tmr_value,
    output logic            tmr_dir,
    output logic            pr_event,
    output logic            zero_event,
    output logic [CH-1:0]   dc_event,
    output logic [CH-1:0]   pwm_out
);
    logic [N-1:0] tmr, tmr_nx, sh_pr;
    logic [PS_W-1:0] ps_cnt;
    logic dir, dir_nx, en_c, tick, bnd, ld;
    pwm_mode_e sh_mode;
    assign en_c = en & sys_clk_en;
    assign tick = en_c & ~tmr_rst & (ps_cnt == prescale);
    assign bnd  = tick & ((sh_pr == '0) |
                  (sh_mode == PWM_EDGE ? (tmr == sh_pr) : ((tmr == '0) & dir)));
    // a disabled block has no running period, so loads apply immediately
    assign ld   = en ? (bnd & (ld_pend | ld_trg)) : ld_trg;
    always_comb begin
        tmr_nx = tmr + N'(1);
        dir_nx = 1'b0;
        if (sh_pr == '0) begin
            tmr_nx = '0;
        end else if (sh_mode == PWM_EDGE) begin
            tmr_nx = (tmr >= sh_pr) ? '0 : tmr + N'(1);
        end else begin
            dir_nx = dir ? (tmr != '0) : (tmr >= sh_pr);
            tmr_nx = dir_nx ? tmr - N'(1) : tmr + N'(1);
        end
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmr        <= '0;
            ps_cnt     <= '0;
            dir        <= 1'b0;
            sh_pr      <= '0;
            sh_mode    <= PWM_EDGE;
            ld_pend    <= 1'b0;
            pr_event   <= 1'b0;
            zero_event <= 1'b0;
        end else begin
            if (tmr_rst) begin
                tmr    <= '0;
                ps_cnt <= '0;
                dir    <= 1'b0;
            end else if (en_c) begin
                ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
                if (tick) begin
                    tmr <= tmr_nx;
                    dir <= dir_nx;
                end
            end
            if (ld) begin
                sh_pr   <= pr_cfg;
                sh_mode <= pwm_mode_e'(mode_cfg);
            end
            ld_pend    <= ~ld & (ld_pend | ld_trg);
            pr_event   <= tick & (tmr == sh_pr);
            zero_event <= tick & (tmr == '0);
        end
    end
    assign tmr_value = tmr;
    assign tmr_dir   = dir;
    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_mc_ch #(.N(N)) u_ch (
            .sys_clk  (sys_clk),
            .sys_rst  (sys_rst),
            .en       (en),
            .tick     (tick),
            .ld       (ld),
            .sh_mode  (sh_mode),
            .tmr      (tmr),
            .dc_cfg   (dc_cfg[i*N +: N]),
            .ph_cfg   (ph_cfg[i*N +: N]),
            .pol      (pol[i]),
            .oen      (oen[i]),
            .dc_event (dc_event[i]),
            .pwm_out  (pwm_out[i])
        );
    end
endmodule

// File: doc/pwm_mc_v2.md
# pwm_mc_v2

Multi-channel PWM generator with parametrised counter width and channel count. CH output channels share one prescaled timebase. The timebase runs in edge-aligned (up-count) or center-aligned (up/down) mode. Period, duty and phase use shadow registers that update only at the period boundary. The block sits beside the SFR file in the microcontroller peripheral subsystem and is driven from already-decoded configuration fields.

## Interface
- N, 16, timer/compare width
- CH, 4, number of output channels
- PS_W, 8, prescaler width
- sys_clk  input  1  system clock; one clock domain
- sys_rst  input  1  synchronous, active-high reset
- sys_clk_en  input  1  chip-level count enable (low-power gate)
- en  input  1  module enable
- mode_cfg  input  1  0 = edge-aligned, 1 = center-aligned (shadowed)
- prescale  input  PS_W  tick every prescale+1 enabled cycles
- pr_cfg  input  N  period value (shadowed)
- dc_cfg  input  CH*N  per-channel duty compare; channel i is bits [i*N +: N] (shadowed)
- ph_cfg  input  CH*N  per-channel phase compare (shadowed)
- pol  input  CH  per-channel output inversion
- oen  input  CH  per-channel output enable
- ld_trg  input  1  one-cycle request to load shadows
- tmr_rst  input  1  one-cycle timer restart
- ld_pend  output  1  shadow load requested, not yet applied
- tmr_value  output  N  current timer
- tmr_dir  output  1  0 = up, 1 = down
- pr_event  output  1  pulse: period match
- zero_event  output  1  pulse: timer at zero on tick
- dc_event  output  CH  pulse per channel: timer equals duty on tick
- pwm_out  output  CH  PWM outputs

## Operation
- Tick condition: en & sys_clk_en & (ps_cnt == prescale).
  - ps_cnt increments on each en & sys_clk_en cycle and wraps to 0 on tick.
  - prescale = 0 gives a tick every enabled cycle.
- Edge mode, on each tick: tmr increments 0..sh_pr, then wraps to 0. tmr_dir stays 0.
- Center mode, on each tick: tmr counts up to sh_pr, then down to 0.
  - tmr_dir flips to 1 on the tick where tmr == sh_pr and tmr_dir = 0.
  - tmr_dir flips to 0 on the tick where tmr == 0 and tmr_dir = 1.
  - Full period is 2*sh_pr ticks.
- sh_pr = 0: tmr holds 0 and tmr_dir holds 0. Every tick is a boundary.
- Boundary:
  - Edge mode: tick with tmr == sh_pr.
  - Center mode: tick with tmr == 0 and tmr_dir = 1. The first boundary after reset is a tick with tmr == 0.
- Shadow load:
  - ld_trg sets ld_pend.
  - At a boundary with ld_pend (or ld_trg in the same cycle), sh_pr, sh_dc[], sh_ph[] and sh_mode load and ld_pend clears.
  - While en = 0, ld_trg loads the shadows on the next edge directly and ld_pend stays 0.
- Channel raw output:
  - Edge mode: raw = (tmr >= sh_ph) & (tmr < sh_dc). sh_dc <= sh_ph gives 0.
  - Center mode: raw = (tmr < sh_dc); sh_ph is ignored.
  - In both modes, sh_dc > sh_pr gives a constant 1 from the phase point on.
- Output stage:
  - out_ff[i] <= raw[i] every cycle while en = 1; out_ff clears when en = 0.
  - pwm_out[i] = (out_ff[i] ^ pol[i]) & oen[i].
- Events, registered and one cycle wide:
  - pr_event <= tick & tmr == sh_pr.
  - zero_event <= tick & tmr == 0.
  - dc_event[i] <= tick & tmr == sh_dc[i].
- Priority (highest first): sys_rst, tmr_rst (tmr = 0, ps_cnt = 0, tmr_dir = 0), tick, hold. tmr_rst does not affect the shadows or ld_pend.
- en = 0: tmr, tmr_dir and ps_cnt hold their values. Events are 0.

## Timing
- Reset values: tmr, ps_cnt, tmr_dir, all shadows, ld_pend, out_ff and all events are 0. pwm_out = pol & oen.
- tmr_value updates on the clock edge of the tick cycle.
- out_ff reflects tmr one cycle later, so pwm_out lags tmr_value by 1 cycle.
- Events are asserted the cycle after their tick.
- A shadow load takes effect on the first tick after the boundary, and is visible on pwm_out one cycle after that tick.
- sys_rst mid-period returns every register to its reset value on the next edge. No partial update.

## Structure
- Shared package pkg_sfrs_definition:
  - typedef pwm_mode_e {PWM_EDGE, PWM_CENTER}.
  - pwm_mc_cfg_t for the packed per-channel dc/ph fields.
- Timebase, prescaler, direction and shadow-control logic live in pwm_mc_v2.
- Sub-module pwm_mc_ch: one instance per channel via generate.
  - Holds sh_dc, sh_ph, the compare logic, out_ff, dc_event and the pol/oen stage.
  - Its shadow load is driven by a common load strobe.

## Test plan
- Edge mode, PR = 9, PH = 2, DC = 5, prescale = 0, pol = 0, oen = 1, ld_trg at start:
  - pwm_out is high for tmr 2..4, i.e. 3 of every 10 cycles.
  - pr_event fires every 10 cycles.
- Center mode, PR = 4, DC = 2:
  - tmr runs 0,1,2,3,4,3,2,1 repeating.
  - pwm_out is high 3 of every 8 ticks, symmetric about tmr = 0.
  - tmr_dir toggles at 4 and at 0.
- prescale = 2, edge mode, PR = 3: tmr advances every 3rd cycle, giving a 12-cycle period.
- Mid-period reconfiguration, DC 5 -> 8 with ld_trg at tmr = 3:
  - ld_pend = 1 until the tmr = 9 boundary.
  - The new duty applies from the next period only; the current period keeps DC = 5.
- tmr_rst at tmr = 6: tmr = 0 and tmr_dir = 0 the next cycle, and the shadows are unchanged. DC = 2 with PH = 2 gives constant pwm_out = pol.
- sys_rst asserted mid-period with pol = 1, oen = 1: all state clears, pwm_out = 1 and all events are 0. Counting resumes from 0 after release.
